tboom_checkpoint_ctrl: RTL

Allocates and recovers the rename checkpoint slots of the free-list buffer. Rename requests one checkpoint per branch. The controller hands out slot tags in program order, frees them when branches resolve correctly, and on a mispredict sequences a single-cycle restore followed by a fixed drain. It sits between rename/branch-resolution logic and the free-list buffer's `checkpoint` / `restore` / `checkpoint_restore_pos` inputs, and drives the rename stall.

---
 rtl/tboom_checkpoint_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/tboom_checkpoint_ctrl.sv
// tboom_checkpoint_ctrl: in-order rename checkpoint slot allocator with mispredict restore/drain sequencing
module tboom_checkpoint_ctrl #(
    parameter int CHECKPOINT_DEPTH = 8,
    parameter int RECOVERY_CYCLES  = 2,
    localparam int TAG_W = $clog2(CHECKPOINT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_alloc_valid,
    output logic             br_alloc_ready,
    output logic [TAG_W-1:0] br_alloc_tag,
    input  logic             br_resolve_valid,
    input  logic [TAG_W-1:0] br_resolve_tag,
    input  logic             br_mispredict,
    output logic             fl_checkpoint,
    output logic             fl_restore,
    output logic [TAG_W-1:0] fl_checkpoint_restore_pos,
    output logic             rename_stall,
    output logic [TAG_W:0]   num_free,
    output logic             invalid_resolve
);
    localparam int CW = $clog2(RECOVERY_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, RESTORE, DRAIN} state_t;
    state_t                      state_q;
    logic [CW-1:0]               cnt_q;
    logic [TAG_W:0]              head_q, tail_q, head_d, tail_d, occ;
    logic [CHECKPOINT_DEPTH-1:0] live_q, live_d, resolved_q, resolved_d;
    logic [TAG_W-1:0]            restore_tag_q, head_idx, tail_idx, dt;
    logic                        invalid_q, alloc, tag_live, mis, ok, retire;
    assign head_idx                  = head_q[TAG_W-1:0];
    assign tail_idx                  = tail_q[TAG_W-1:0];
    assign occ                       = tail_q - head_q;
    assign num_free                  = (TAG_W+1)'(CHECKPOINT_DEPTH) - occ;
    assign br_alloc_ready            = (state_q == IDLE) && (num_free != '0);
    assign alloc                     = br_alloc_valid && br_alloc_ready;
    assign br_alloc_tag              = tail_idx;
    assign fl_checkpoint             = alloc;
    assign fl_restore                = (state_q == RESTORE);
    assign fl_checkpoint_restore_pos = fl_restore ? restore_tag_q : tail_idx;
    assign rename_stall              = (state_q != IDLE);
    assign invalid_resolve           = invalid_q;
    assign tag_live                  = live_q[br_resolve_tag];
    assign mis                       = br_resolve_valid && br_mispredict && tag_live;
    assign ok                        = br_resolve_valid && !br_mispredict && tag_live;
    assign dt                        = br_resolve_tag - head_idx;
    // a mispredict of the head slot empties the buffer, so it must not also retire
    assign retire = live_q[head_idx] && resolved_q[head_idx] && !(mis && dt == '0);
    assign head_d = head_q + {{TAG_W{1'b0}}, retire};
    assign tail_d = mis ? head_q + {1'b0, dt} : tail_q + {{TAG_W{1'b0}}, alloc};
    always_comb begin
        live_d     = live_q;
        resolved_d = resolved_q;
        if (alloc) begin
            live_d[tail_idx]     = 1'b1;
            resolved_d[tail_idx] = 1'b0;
        end
        if (ok) resolved_d[br_resolve_tag] = 1'b1;
        if (retire) live_d[head_idx] = 1'b0;
        if (mis) begin
            for (int i = 0; i < CHECKPOINT_DEPTH; i++) begin
                if (TAG_W'(i) - head_idx >= dt) live_d[i] = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            live_q        <= '0;
            resolved_q    <= '0;
            restore_tag_q <= '0;
            invalid_q     <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            live_q     <= live_d;
            resolved_q <= resolved_d;
            invalid_q  <= invalid_q || (br_resolve_valid && !tag_live);
            if (mis) begin
                state_q       <= RESTORE;
                cnt_q         <= CW'(RECOVERY_CYCLES - 1);
                restore_tag_q <= br_resolve_tag;
            end else if (state_q == RESTORE) begin
                state_q <= DRAIN;
            end else if (state_q == DRAIN) begin
                if (cnt_q == '0) state_q <= IDLE;
                else cnt_q <= cnt_q - 1'b1;
            end
        end
    end
endmodule
